// File: rtl/led_fade_scheduler.sv
// led_fade_scheduler
//   Round-robin sequencer for a bank of breathing-PWM fade engines. One
//   engine animates at a time: it gets a one-cycle start pulse and a captured
//   hold value. The sequencer waits for that engine's completion pulse (or a
//   timeout), waits out a dark gap, then moves to the next enabled channel.
//   The next channel is chosen in chase order or in ping-pong order.
//
// Ports
//   clk         system clock (rising edge)
//   rst         synchronous, active-high reset
//   enable      run request, level-sensitive; never aborts a running channel
//   mode        0 = chase (ascending, wraps), 1 = ping-pong (bounces)
//   en_mask     participating channels, bit i = channel i
//   hold        hold time, captured into t2 when a channel is issued
//   done        per-engine one-cycle completion pulses
//   start       one-hot, one-cycle start pulse to the selected engine
//   t2          captured hold value for the active channel
//   active_ch   index of the current or most recent channel
//   busy        high in every state except IDLE
//   timeout_err sticky completion-timeout flag, cleared only by rst
module led_fade_scheduler #(
   parameter int          N_CH    = 4,
   parameter int          T2_W    = 13,
   parameter logic [15:0] GAP     = 16'd100,
   parameter logic [19:0] TIMEOUT = 20'd1000000,
   localparam int         CH_W    = $clog2(N_CH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enable,
   input  logic              mode,
   input  logic [N_CH-1:0]   en_mask,
   input  logic [T2_W-1:0]   hold,
   input  logic [N_CH-1:0]   done,
   output logic [N_CH-1:0]   start,
   output logic [T2_W-1:0]   t2,
   output logic [CH_W-1:0]   active_ch,
   output logic              busy,
   output logic              timeout_err
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_GAP   = 2'd3
   } state_t;

   // GAP=0 still spends one cycle in the gap state. This is the same as GAP=1.
   localparam logic [15:0] GAP_LAST     = (GAP == 16'd0) ? 16'd0 : GAP - 16'd1;
   // wait_cnt_reg counts completed WAIT cycles. The timeout fires on the edge
   // where the count would reach TIMEOUT.
   localparam logic [19:0] TIMEOUT_LAST = TIMEOUT - 20'd1;

   state_t            state_reg, state_next;
   logic [CH_W-1:0]   active_ch_reg;
   logic              dir_up_reg;
   logic              first_sel_reg;   // next selection searches from index 0 inclusive
   logic [T2_W-1:0]   t2_reg;
   logic [19:0]       wait_cnt_reg;
   logic [15:0]       gap_cnt_reg;
   logic              timeout_err_reg;

   logic              do_select;
   logic              done_cur;
   logic              wait_hit;
   logic              gap_end;
   logic              run_ok;

   logic [CH_W-1:0]   low_idx, up_idx, dn_idx, sel_idx;
   logic              up_found, dn_found, sel_dir_up;

   assign done_cur = done[active_ch_reg];
   assign wait_hit = (wait_cnt_reg == TIMEOUT_LAST);
   assign gap_end  = (gap_cnt_reg >= GAP_LAST);
   assign run_ok   = enable && (|en_mask);

   // Channel search around the pointer:
   //   low_idx = lowest enabled channel
   //   up_idx  = nearest enabled channel above the pointer
   //   dn_idx  = nearest enabled channel below the pointer
   always_comb begin
      low_idx  = '0;
      up_found = 1'b0;
      up_idx   = '0;
      dn_found = 1'b0;
      dn_idx   = '0;
      for (int i = N_CH - 1; i >= 0; i--) begin
         if (en_mask[i]) begin
            low_idx = CH_W'(i);
         end
         if (en_mask[i] && (i > int'(active_ch_reg))) begin
            up_found = 1'b1;
            up_idx   = CH_W'(i);
         end
      end
      for (int i = 0; i < N_CH; i++) begin
         if (en_mask[i] && (i < int'(active_ch_reg))) begin
            dn_found = 1'b1;
            dn_idx   = CH_W'(i);
         end
      end
   end

   // Choose the next channel. When no other channel is enabled, both modes
   // fall back to the pointer itself, so a lone channel is reissued.
   always_comb begin
      sel_idx    = active_ch_reg;
      sel_dir_up = dir_up_reg;
      if (first_sel_reg) begin
         sel_idx = low_idx;
      end else if (!mode) begin
         sel_idx = up_found ? up_idx : low_idx;
      end else if (dir_up_reg) begin
         if (up_found) begin
            sel_idx = up_idx;
         end else if (dn_found) begin
            sel_idx    = dn_idx;
            sel_dir_up = 1'b0;
         end
      end else begin
         if (dn_found) begin
            sel_idx = dn_idx;
         end else if (up_found) begin
            sel_idx    = up_idx;
            sel_dir_up = 1'b1;
         end
      end
   end

   // Next-state logic
   always_comb begin
      state_next = state_reg;
      do_select  = 1'b0;
      case (state_reg)
         S_IDLE: begin
            if (run_ok) begin
               do_select  = 1'b1;
               state_next = S_ISSUE;
            end
         end
         S_ISSUE: begin
            state_next = S_WAIT;
         end
         S_WAIT: begin
            if (done_cur || wait_hit) begin
               state_next = S_GAP;
            end
         end
         S_GAP: begin
            if (gap_end) begin
               if (run_ok) begin
                  do_select  = 1'b1;
                  state_next = S_ISSUE;
               end else begin
                  state_next = S_IDLE;
               end
            end
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg       <= S_IDLE;
         active_ch_reg   <= '0;
         dir_up_reg      <= 1'b1;
         first_sel_reg   <= 1'b1;
         t2_reg          <= '0;
         wait_cnt_reg    <= '0;
         gap_cnt_reg     <= '0;
         timeout_err_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         if (do_select) begin
            active_ch_reg <= sel_idx;
            dir_up_reg    <= sel_dir_up;
            first_sel_reg <= 1'b0;
         end
         case (state_reg)
            S_ISSUE: begin
               t2_reg       <= hold;
               wait_cnt_reg <= '0;
            end
            S_WAIT: begin
               gap_cnt_reg <= '0;
               if (wait_cnt_reg != 20'hFFFFF) begin
                  wait_cnt_reg <= wait_cnt_reg + 20'd1;
               end
               // A completion on the timeout edge still counts as on time.
               if (wait_hit && !done_cur) begin
                  timeout_err_reg <= 1'b1;
               end
            end
            S_GAP: begin
               if (gap_cnt_reg != 16'hFFFF) begin
                  gap_cnt_reg <= gap_cnt_reg + 16'd1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   // start is a pure decode of ISSUE, one bit per channel
   generate
      for (genvar gi = 0; gi < N_CH; gi++) begin : g_start
         assign start[gi] = (state_reg == S_ISSUE) && (active_ch_reg == CH_W'(gi));
      end
   endgenerate

   assign t2          = t2_reg;
   assign active_ch   = active_ch_reg;
   assign busy        = (state_reg != S_IDLE);
   assign timeout_err = timeout_err_reg;

endmodule
